fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side controller for the project's synchronous FIFO. It watches the FIFO status flags and issues `fifo_rd_enable` so the FIFO is never read while empty. It captures the FIFO's registered read data, one cycle after each read, into a 2-entry output buffer. Downstream logic receives the words over a valid/ready stream at one word per clock sustained. It sits between each FIFO instance and the consumer logic (demux/arbiter stages) in the datapath.

## Interface
- `DATA_WIDTH`, default 10, word width; must match the FIFO `data_width`.
- `COUNT_WIDTH`, default 16, width of the delivered-word counter (present only with `FIFO_READER_STATS_EN`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `enable`  in  1  permits new FIFO reads while high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_error`  in  1  FIFO error flag (count overflow).
- `fifo_data`  in  DATA_WIDTH  FIFO registered read data, valid the cycle after a read.
- `fifo_rd_enable`  out  1  read strobe to the FIFO; combinational.
- `data_out`  out  DATA_WIDTH  output word; registered.
- `valid_out`  out  1  `data_out` holds a word.
- `ready_in`  in  1  consumer accepts `data_out` this cycle.
- `state`  out  2  FSM state: IDLE=0, RUN=1, HALT=2.
- `error`  out  1  sticky error.
- `word_count`  out  COUNT_WIDTH  delivered words, wraps; `FIFO_READER_STATS_EN` only.

## Operation
- Internal state:
  - `inflight`: 1 bit, registered copy of `fifo_rd_enable`.
  - `occ`: 0..2, output buffer occupancy.
  - 2-entry buffer; its head entry drives `data_out`.
- `pop` = `valid_out & ready_in`.
- `fifo_rd_enable` = `(state==RUN) & !fifo_empty & (occ + inflight - pop < 2)`.
- When `inflight==1`, `fifo_data` is written into the buffer tail at the next edge.
  - Simultaneous pop and capture: buffer shifts and captures in the same edge; `occ` stays the same.
- `valid_out` = `(occ != 0)`.
- `data_out` holds stable while `valid_out & !ready_in`. Words leave in FIFO order.
- FSM:
  - IDLE -> RUN when `enable==1`.
  - RUN -> IDLE when `enable==0`.
  - IDLE or RUN -> HALT when `fifo_error==1`. This takes priority over the enable transitions.
  - HALT is left only by reset.
- In IDLE and HALT, no new reads are issued. An in-flight word is still captured, and buffered words still drain to the consumer.
- `error` sets on the cycle after `fifo_error` is sampled high and stays set until reset.
- Reset (`reset==0` at an edge), including mid-transfer:
  - `state`=IDLE, `occ`=0, `inflight`=0, `data_out`=0, `valid_out`=0, `error`=0, `word_count`=0.
  - An in-flight FIFO word is discarded. The FIFO is reset by the same signal.
  - `fifo_rd_enable` is forced to 0 while `reset==0`.

## Timing
- Latency: `fifo_rd_enable` high in cycle n -> word captured at end of n+1 -> `valid_out` high in n+2.
- First word after `enable` rises (FIFO non-empty, state IDLE): read in cycle n+1, `valid_out` in n+3.
- Throughput: 1 word/clk while the FIFO is non-empty and `ready_in` stays high.
- Backpressure: with `ready_in` low, at most 2 words are buffered, including the in-flight word. After that, `fifo_rd_enable` stays 0.
- `fifo_empty` is used in the same cycle. The FIFO updates its count on the same edge as the read, so no read is ever issued to an empty FIFO.

## Configuration
- `FIFO_READER_STATS_EN` defined:
  - `word_count` port exists and increments by 1 on every `pop`.
  - It wraps from 2^COUNT_WIDTH−1 to 0 and resets to 0.
- `FIFO_READER_STATS_EN` undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then `enable=1`, FIFO preloaded with 0x001..0x008, `ready_in=1`:
  - 8 reads on consecutive cycles.
  - `data_out` shows 0x001..0x008 on 8 consecutive `valid_out` cycles.
  - `word_count`=8.
- Same preload, `ready_in=0` for 10 cycles, then 1:
  - Exactly 2 reads are issued, then `fifo_rd_enable` stays 0.
  - `data_out` holds 0x001 while `ready_in` is low.
  - Full sequence 0x001..0x008 is delivered with no loss or duplicates.
- FIFO holds one word 0x155; writer adds 0x0AA 3 cycles later:
  - Never `fifo_rd_enable=1` while `fifo_empty=1`.
  - Outputs are 0x155 then 0x0AA.
- `enable` dropped the cycle after a read:
  - In-flight word is still delivered.
  - `state`=IDLE, no further reads.
  - Re-enable resumes at the next FIFO word.
- `fifo_error` pulsed 1 cycle in RUN:
  - `state`=HALT and `error`=1 next cycle, sticky.
  - No further reads; buffered words drain.
  - `reset=0` clears everything to the reset values.
- `reset=0` asserted with `occ`=2 and a read in flight:
  - Next cycle: `valid_out`=0, `data_out`=0, `state`=IDLE.
  - After release, no stale word appears.

Source files
------------

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the synchronous FIFO, delivering words over valid/ready through a 2-entry buffer.
// Optional delivered-word counter enabled by FIFO_READER_STATS_EN.
module fifo_reader #(
  parameter int DATA_WIDTH = 10
`ifdef FIFO_READER_STATS_EN
  , parameter int COUNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_error,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [1:0]            state,
  output logic                  error
`ifdef FIFO_READER_STATS_EN
  , output logic [COUNT_WIDTH-1:0] word_count
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  state_t                state_q, state_d;
  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d, base;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic                  error_q;
  logic                  pop;
  logic [2:0]            load;
  assign valid_out = occ_q != 2'd0;
  assign pop = valid_out & ready_in;
  // Words already committed to the buffer after this cycle's pop, counting the in-flight one.
  assign load = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign fifo_rd_enable = reset & (state_q == RUN) & ~fifo_empty & (load < 3'd2);
  assign data_out = buf_q[0];
  assign state = state_q;
  assign error = error_q;
  always_comb begin
    state_d = (state_q != HALT && fifo_error) ? HALT :
              (state_q == IDLE && enable)    ? RUN  :
              (state_q == RUN && !enable)    ? IDLE : state_q;
    base = occ_q - {1'b0, pop};
    buf_d[0] = pop ? buf_q[1] : buf_q[0];
    buf_d[1] = buf_q[1];
    if (inflight_q && base == 2'd0) buf_d[0] = fifo_data;
    if (inflight_q && base != 2'd0) buf_d[1] = fifo_data;
    occ_d = base + {1'b0, inflight_q};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_enable;
      occ_q      <= occ_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      error_q    <= error_q | fifo_error;
    end
  end
`ifdef FIFO_READER_STATS_EN
  logic [COUNT_WIDTH-1:0] count_q;
  assign word_count = count_q;
  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else if (pop) count_q <= count_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: table-driven cycle vectors plus FIFO-model sequences for fifo_reader.
module tb_fifo_reader;
  logic clk = 1'b0;
  logic reset, enable, fifo_error, ready_in, use_model;
  logic t_emp;
  logic [9:0] t_din;
  logic fifo_empty, fifo_rd_enable, valid_out, error;
  logic [9:0] fifo_data, data_out;
  logic [1:0] state;
`ifdef FIFO_READER_STATS_EN
  logic [15:0] word_count;
`endif
  always #5 clk = ~clk;
  fifo_reader dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_error(fifo_error), .fifo_data(fifo_data), .fifo_rd_enable(fifo_rd_enable),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .state(state), .error(error)
`ifdef FIFO_READER_STATS_EN
    , .word_count(word_count)
`endif
  );
  logic [9:0] mem [256];
  int rp = 0, wp = 0;
  logic [9:0] m_data = '0;
  assign fifo_empty = use_model ? (rp == wp) : t_emp;
  assign fifo_data  = use_model ? m_data : t_din;
  always @(posedge clk) begin
    if (!reset) rp <= wp;
    else if (use_model && fifo_rd_enable) begin
      m_data <= mem[rp[7:0]];
      rp <= rp + 1;
    end
  end
  int total = 0, passed = 0;
  int cyc = 0, reads, bad_rd, ng, first_rd, first_vld, last_vld, n, hold_bad;
  logic [9:0] got [32];
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  task automatic push(input logic [9:0] d);
    mem[wp[7:0]] = d;
    wp++;
  endtask
  task automatic clr();
    reads = 0; bad_rd = 0; ng = 0; first_rd = -1; first_vld = -1; last_vld = -1;
  endtask
  task automatic tick();
    @(negedge clk); #1;
    if (fifo_rd_enable) begin
      reads++;
      if (first_rd < 0) first_rd = cyc;
      if (fifo_empty) bad_rd++;
    end
    if (valid_out) begin
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
    end
    if (valid_out && ready_in && ng < 32) begin
      got[ng] = data_out;
      ng++;
    end
    cyc++;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    use_model = 1'b1; reset = 1'b0; enable = 1'b0; ready_in = 1'b0; fifo_error = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    clr();
  endtask
  typedef struct {
    logic rn, en, emp, err, rdy;
    logic [9:0] din;
    logic rd, vld, cd;
    logic [9:0] dout;
    logic [1:0] st;
    logic er;
  } vec_t;
  vec_t tv [15];
  initial begin
    tv[0]  = '{0,1,0,0,1,10'h000, 0,0,1,10'h000,2'd0,0};
    tv[1]  = '{1,1,0,0,1,10'h000, 0,0,1,10'h000,2'd0,0};
    tv[2]  = '{1,1,0,0,0,10'h000, 1,0,0,10'h000,2'd1,0};
    tv[3]  = '{1,1,0,0,0,10'h011, 1,0,0,10'h000,2'd1,0};
    tv[4]  = '{1,1,0,0,0,10'h022, 0,1,1,10'h011,2'd1,0};
    tv[5]  = '{1,1,0,0,0,10'h3FF, 0,1,1,10'h011,2'd1,0};
    tv[6]  = '{1,1,0,0,1,10'h3FF, 1,1,1,10'h011,2'd1,0};
    tv[7]  = '{1,1,1,0,1,10'h033, 0,1,1,10'h022,2'd1,0};
    tv[8]  = '{1,0,0,0,0,10'h000, 1,1,1,10'h033,2'd1,0};
    tv[9]  = '{1,0,0,0,1,10'h044, 0,1,1,10'h033,2'd0,0};
    tv[10] = '{1,0,0,1,1,10'h000, 0,1,1,10'h044,2'd0,0};
    tv[11] = '{1,1,0,0,1,10'h000, 0,0,0,10'h000,2'd2,1};
    tv[12] = '{1,1,0,0,1,10'h000, 0,0,0,10'h000,2'd2,1};
    tv[13] = '{0,1,0,0,1,10'h000, 0,0,0,10'h000,2'd2,1};
    tv[14] = '{1,0,0,0,1,10'h000, 0,0,1,10'h000,2'd0,0};
    use_model = 1'b0; reset = 1'b0; enable = 1'b0; fifo_error = 1'b0; ready_in = 1'b0;
    t_emp = 1'b1; t_din = '0;
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 15; i++) begin
      reset = tv[i].rn; enable = tv[i].en; t_emp = tv[i].emp;
      fifo_error = tv[i].err; ready_in = tv[i].rdy; t_din = tv[i].din;
      @(negedge clk); #1;
      chk($sformatf("v%0d_rd", i), fifo_rd_enable, tv[i].rd);
      chk($sformatf("v%0d_valid", i), valid_out, tv[i].vld);
      chk($sformatf("v%0d_state", i), state, tv[i].st);
      chk($sformatf("v%0d_error", i), error, tv[i].er);
      if (tv[i].cd) chk($sformatf("v%0d_data", i), data_out, tv[i].dout);
      @(posedge clk); #1;
    end
    // streaming at full rate
    do_reset();
    for (int i = 1; i <= 8; i++) push(10'(i));
    enable = 1'b1; ready_in = 1'b1; n = cyc;
    repeat (20) tick();
    chk("A_count", ng, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("A_word%0d", i), got[i], i + 1);
    chk("A_reads", reads, 8);
    chk("A_no_empty_rd", bad_rd, 0);
    chk("A_first_rd", first_rd, n + 1);
    chk("A_first_vld", first_vld, n + 3);
    chk("A_span", last_vld - first_vld, 7);
`ifdef FIFO_READER_STATS_EN
    chk("A_word_count", word_count, 8);
`endif
    // backpressure
    do_reset();
    for (int i = 1; i <= 8; i++) push(10'(i));
    enable = 1'b1; ready_in = 1'b0; hold_bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (valid_out && data_out != 10'h001) hold_bad++;
    end
    chk("B_reads", reads, 2);
    chk("B_valid", valid_out, 1);
    chk("B_hold", hold_bad, 0);
    ready_in = 1'b1;
    repeat (20) tick();
    chk("B_count", ng, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("B_word%0d", i), got[i], i + 1);
    chk("B_no_empty_rd", bad_rd, 0);
    // late writer
    do_reset();
    push(10'h155);
    enable = 1'b1; ready_in = 1'b1;
    repeat (3) tick();
    push(10'h0AA);
    repeat (10) tick();
    chk("C_count", ng, 2);
    chk("C_word0", got[0], 10'h155);
    chk("C_word1", got[1], 10'h0AA);
    chk("C_reads", reads, 2);
    chk("C_no_empty_rd", bad_rd, 0);
    // enable dropped right after a read
    do_reset();
    for (int i = 1; i <= 4; i++) push(10'(i));
    enable = 1'b1; ready_in = 1'b1;
    for (int k = 0; k < 10 && reads == 0; k++) tick();
    chk("D_first_read", reads, 1);
    enable = 1'b0;
    repeat (8) tick();
    chk("D_state", state, 0);
    chk("D_reads", reads, 2);
    chk("D_count", ng, 2);
    chk("D_word0", got[0], 1);
    chk("D_word1", got[1], 2);
    enable = 1'b1;
    repeat (12) tick();
    chk("D_count2", ng, 4);
    chk("D_word2", got[2], 3);
    chk("D_word3", got[3], 4);
    chk("D_reads2", reads, 4);
    // error pulse in RUN
    do_reset();
    for (int i = 1; i <= 8; i++) push(10'(i));
    enable = 1'b1; ready_in = 1'b0;
    repeat (3) tick();
    fifo_error = 1'b1;
    tick();
    fifo_error = 1'b0;
    chk("E_state", state, 2);
    chk("E_error", error, 1);
    repeat (5) tick();
    chk("E_reads", reads, 2);
    chk("E_sticky", error, 1);
    chk("E_state_hold", state, 2);
    ready_in = 1'b1;
    repeat (5) tick();
    chk("E_drain", ng, 2);
    chk("E_word0", got[0], 1);
    chk("E_word1", got[1], 2);
    reset = 1'b0;
    tick();
    chk("E_rst_state", state, 0);
    chk("E_rst_error", error, 0);
    chk("E_rst_valid", valid_out, 0);
    // reset mid-transfer
    do_reset();
    for (int i = 1; i <= 8; i++) push(10'(i));
    enable = 1'b1; ready_in = 1'b0;
    repeat (3) tick();
    chk("F_pre_valid", valid_out, 1);
    reset = 1'b0;
    tick();
    chk("F_valid", valid_out, 0);
    chk("F_data", data_out, 0);
    chk("F_state", state, 0);
    reset = 1'b1; enable = 1'b1; ready_in = 1'b1;
    clr();
    push(10'h0AB);
    repeat (10) tick();
    chk("F_count", ng, 1);
    chk("F_word0", got[0], 10'h0AB);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
